core_run_ctrl: RTL
==================

// Module: core_run_ctrl
// PURPOSE
//  Execution controller between board clock and single-cycle core; replaces ad-hoc clk_div/step clock muxing.
//  Produces one clock-enable (cpu_ce) for CPU state updates; programmable divider, four run modes, NUM_BP PC breakpoints.
//  Sits beside the core; pc comes from core PC register, cpu_ce gates PC/regfile/mem writes, status goes to debug outputs.
// PARAMETERS
//  DIV_W    8   width of div_ratio; tick every div_ratio+1 clk cycles
//  NUM_BP   4   number of PC breakpoint channels
//  PC_W     32  PC / breakpoint address width
//  BURST_W  16  width of burst_len / remaining-count
// PORTS
//  clk          in   1            system clock
//  rst          in   1            synchronous, active-high reset
//  div_ratio    in   DIV_W        divider terminal count
//  mode         in   2            0 HALT, 1 RUN, 2 STEP, 3 BURST
//  step_btn     in   1            step level, already synchronised/debounced upstream
//  resume       in   1            start request (RUN/BURST), sampled only in HALT
//  burst_len    in   BURST_W      instruction count for BURST
//  bp_en        in   NUM_BP       per-channel breakpoint enable
//  bp_addr      in   NUM_BP*PC_W  channel i at [i*PC_W +: PC_W]
//  pc           in   PC_W         current core PC (registered in core)
//  cpu_ce       out  1            one-cycle enable: core executes pc this cycle
//  halted       out  1            1 when state==HALT
//  bp_hit       out  NUM_BP       sticky per-channel hit flags
//  state        out  2            0 HALT, 1 RUN, 2 STEP, 3 BURST
//  retired_cnt  out  32           count of cpu_ce pulses
// BEHAVIOUR
//  Reset: state HALT, halted 1, cpu_ce 0, bp_hit 0, retired_cnt 0, div_cnt 0, step_q 0, burst_rem 0, skip 0.
//  Divider: tick = (div_cnt >= div_ratio); on tick div_cnt<=0 else +1. Free-running in all states.
//   div_ratio 0 -> tick every cycle; lowering div_ratio below div_cnt -> tick next cycle (no wrap through 2^DIV_W).
//  step_rise = step_btn & ~step_q; step_q registered every cycle.
//  match = bp_en[i] && pc==bp_addr[i], per channel; bp_fire = |match && !skip.
//  cpu_ce is combinational from registered state/counters and pc; forced 0 whenever mode==HALT.
//  HALT: cpu_ce 0. Next state (priority order):
//   mode==RUN & resume -> RUN; mode==BURST & resume & burst_len!=0 -> BURST, burst_rem<=burst_len;
//   mode==BURST & resume & burst_len==0 -> stay HALT; mode==STEP & step_rise -> STEP.
//   Any leave from HALT: bp_hit<=0, skip<=1.
//  RUN: cpu_ce = tick & !bp_fire. On tick & bp_fire: cpu_ce 0, bp_hit|=match (all matches), ->HALT.
//  STEP: cpu_ce = tick (breakpoints ignored); after the one pulse ->HALT. Exactly one cpu_ce per step_rise.
//  BURST: as RUN plus burst_rem-- on each cpu_ce; cpu_ce with burst_rem==1 -> HALT.
//   bp_fire on last burst tick: bp wins, no cpu_ce, burst_rem unchanged, bp_hit set.
//  skip cleared on first cpu_ce after leaving HALT: resuming at a breakpoint PC executes it once.
//  mode changed to HALT in RUN/STEP/BURST: cpu_ce 0 same cycle, state HALT next edge; bp_hit unchanged.
//  mode changed between non-HALT values while running: ignored until next HALT.
//  resume/step_rise outside HALT ignored; step_btn held high gives one step only.
//  retired_cnt +1 per cpu_ce, wraps 2^32-1 -> 0. halted registered = (next state==HALT).
//  Latency: resume at edge N -> state RUN after N; first cpu_ce on first tick at/after cycle N+1.
//  rst mid-run: all state to reset values next edge, no cpu_ce during rst.
// TESTING
//  div_ratio=3, mode=RUN, resume pulse -> cpu_ce every 4th clk; retired_cnt=5 after 20 clks of RUN.
//  mode=STEP, div_ratio=0, step_btn held high 10 clks -> exactly one cpu_ce, state back to 0, retired_cnt +1.
//  RUN, bp_en=4'b0101, bp_addr0=0x10, bp_addr2=0x10, pc reaches 0x10 -> no cpu_ce at 0x10, bp_hit=4'b0101, halted=1.
//  Resume from that halt -> cpu_ce with pc=0x10, bp_hit cleared, later return to 0x10 halts again.
//  BURST burst_len=3, div_ratio=1 -> exactly 3 cpu_ce 2 clks apart, then HALT; burst_len=0 + resume -> stays HALT.
//  rst asserted mid-BURST -> next edge: state 0, cpu_ce 0, retired_cnt 0, bp_hit 0; retired_cnt preset 0xFFFFFFFF +1 -> 0.

Source files
------------

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: single clock-enable controller with divider, HALT/RUN/STEP/BURST modes and PC breakpoints
module core_run_ctrl #(
  parameter int DIV_W   = 8,
  parameter int NUM_BP  = 4,
  parameter int PC_W    = 32,
  parameter int BURST_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIV_W-1:0]       div_ratio,
  input  logic [1:0]             mode,
  input  logic                   step_btn,
  input  logic                   resume,
  input  logic [BURST_W-1:0]     burst_len,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0]        pc,
  output logic                   cpu_ce,
  output logic                   halted,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic [1:0]             state,
  output logic [31:0]            retired_cnt
);
  typedef enum logic [1:0] {HALT, RUN, STEP, BURST} state_t;
  state_t st, nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [BURST_W-1:0] burst_rem;
  logic step_q, skip, tick, step_rise, bp_fire, run_like, leave;
  logic [NUM_BP-1:0] match;
  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    assign match[i] = bp_en[i] && pc == bp_addr[i*PC_W +: PC_W];
  end
  assign tick      = div_cnt >= div_ratio;
  assign step_rise = step_btn && !step_q;
  assign bp_fire   = |match && !skip;
  assign run_like  = st == RUN || st == BURST;
  assign cpu_ce    = !rst && mode != 2'd0 && tick && (st == STEP || (run_like && !bp_fire));
  assign leave     = st == HALT && nxt != HALT;
  assign state     = st;
  always_comb
    nxt = st == HALT ? (mode == 2'd1 && resume ? RUN :
                        mode == 2'd3 && resume && burst_len != '0 ? BURST :
                        mode == 2'd2 && step_rise ? STEP : HALT) :
          (mode == 2'd0 || (run_like && tick && bp_fire) ||
           (cpu_ce && (st == STEP || (st == BURST && burst_rem == BURST_W'(1))))) ? HALT : st;
  always_ff @(posedge clk)
    if (rst) begin
      st          <= HALT;
      halted      <= 1'b1;
      bp_hit      <= '0;
      retired_cnt <= '0;
      div_cnt     <= '0;
      step_q      <= 1'b0;
      burst_rem   <= '0;
      skip        <= 1'b0;
    end else begin
      st      <= nxt;
      halted  <= nxt == HALT;
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      step_q  <= step_btn;
      if (cpu_ce) begin
        retired_cnt <= retired_cnt + 32'd1;
        skip        <= 1'b0;
      end
      if (leave) begin
        bp_hit <= '0;
        skip   <= 1'b1;
      end
      if (leave && nxt == BURST) burst_rem <= burst_len;
      else if (st == BURST && cpu_ce) burst_rem <= burst_rem - BURST_W'(1);
      if (run_like && mode != 2'd0 && tick && bp_fire) bp_hit <= bp_hit | match;
    end
endmodule
